// File: rtl/magic_pkg.sv
// Shared types and helpers for the streaming magic-square checker.
package magic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide enough for N cells of W bits each, so line sums never wrap.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/magic_sum_cmp.sv
// Purpose: equality compare of a candidate line sum against the reference sum.
// Latency: combinational, 0 cycles; the parent registers mismatch into its fail flag.
// Backpressure: none, pure function of its inputs.
module magic_sum_cmp #(
    parameter int SW = 6
) (
    input  logic [SW-1:0] cand_sum,
    input  logic [SW-1:0] ref_sum,
    output logic          mismatch
);

    assign mismatch = (cand_sum != ref_sum);

endmodule

// File: rtl/magic_square_seq.sv
// Purpose: streams an NxN grid row-major, checks all row/column/diagonal sums; MAGIC_NORMAL_CHECK_EN adds a 1..N^2 uniqueness check.
// Latency: done rises N+2 edges after the edge accepting the last cell (N+3 counting that edge).
// Backpressure: cell_ready is high only in LOAD; cell_valid gaps of any length stall without state change.
module magic_square_seq
    import magic_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 4,
    localparam int SW = sum_width(N, W)
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          start,
    input  logic          cell_valid,
    input  logic [W-1:0]  cell_data,
    output logic          cell_ready,
    output logic          done,
    output logic          it_is_magic,
    output logic [SW-1:0] magic_constant
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(N + 2);
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    state_t        state, state_nxt;
    logic [RW-1:0] row, col;
    logic [KW-1:0] k;
    logic [SW-1:0] row_acc, diag_acc, anti_acc, ref_sum;
    logic [SW-1:0] col_acc [N];
    logic          fail;

    logic          accept, start_take, row_end, last_cell, on_anti;
    logic [SW-1:0] cell_ext, row_sum, chk_sum;
    logic          row_mis, chk_mis, cell_bad;

    assign accept     = (state == LOAD) && cell_valid;
    assign start_take = start && ((state == IDLE) || (state == DONE));
    assign row_end    = (col == LAST);
    assign last_cell  = row_end && (row == LAST);
    assign on_anti    = ((int'(row) + int'(col)) == N - 1);
    assign cell_ext   = SW'(cell_data);
    assign row_sum    = row_acc + cell_ext;

    // CHECK walks columns first, then the main and anti diagonals.
    always_comb begin
        chk_sum = '0;
        for (int i = 0; i < N; i++)
            if (int'(k) == i) chk_sum = col_acc[i];
        if (int'(k) == N)     chk_sum = diag_acc;
        if (int'(k) == N + 1) chk_sum = anti_acc;
    end

    magic_sum_cmp #(.SW(SW)) u_row_cmp (
        .cand_sum (row_sum),
        .ref_sum  (ref_sum),
        .mismatch (row_mis)
    );

    magic_sum_cmp #(.SW(SW)) u_chk_cmp (
        .cand_sum (chk_sum),
        .ref_sum  (ref_sum),
        .mismatch (chk_mis)
    );

`ifdef MAGIC_NORMAL_CHECK_EN
    logic [N*N-1:0] seen;

    // Out-of-range values fall through with cell_bad left at 1.
    always_comb begin
        cell_bad = 1'b1;
        for (int i = 0; i < N*N; i++)
            if (int'(cell_data) == i + 1) cell_bad = seen[i];
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            seen <= '0;
        end else if (start_take) begin
            seen <= '0;
        end else if (accept) begin
            for (int i = 0; i < N*N; i++)
                if (int'(cell_data) == i + 1) seen[i] <= 1'b1;
        end
    end
`else
    assign cell_bad = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept && last_cell) state_nxt = CHECK;
            CHECK:   if (k == KW'(N + 1)) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cell_ready     = (state == LOAD);
        done           = (state == DONE);
        it_is_magic    = (state == DONE) && !fail;
        magic_constant = (state == DONE) ? ref_sum : '0;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            row      <= '0;
            col      <= '0;
            k        <= '0;
            row_acc  <= '0;
            diag_acc <= '0;
            anti_acc <= '0;
            ref_sum  <= '0;
            fail     <= 1'b0;
            for (int i = 0; i < N; i++) col_acc[i] <= '0;
        end else if (start_take) begin
            row      <= '0;
            col      <= '0;
            k        <= '0;
            row_acc  <= '0;
            diag_acc <= '0;
            anti_acc <= '0;
            ref_sum  <= '0;
            fail     <= 1'b0;
            for (int i = 0; i < N; i++) col_acc[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++)
                if (int'(col) == i) col_acc[i] <= col_acc[i] + cell_ext;
            if (row == col) diag_acc <= diag_acc + cell_ext;
            if (on_anti)    anti_acc <= anti_acc + cell_ext;
            if (cell_bad)   fail     <= 1'b1;
            if (row_end) begin
                row_acc <= '0;
                col     <= '0;
                row     <= last_cell ? '0 : row + 1'b1;
                // Row 0 defines the reference; later rows are checked against it.
                if (row == '0)   ref_sum <= row_sum;
                else if (row_mis) fail   <= 1'b1;
            end else begin
                row_acc <= row_sum;
                col     <= col + 1'b1;
            end
            if (last_cell) k <= '0;
        end else if (state == CHECK) begin
            if (chk_mis) fail <= 1'b1;
            k <= k + 1'b1;
        end
    end

endmodule

// File: tb/tb_magic_square_seq.sv
// Directed plus randomized bench for magic_square_seq: N=3/W=4 and N=4/W=5 instances against a sum-based reference model.
module tb_magic_square_seq;

    logic       clock;
    logic       reset_L;

    logic       start3, valid3, ready3, done3, magic3;
    logic [3:0] data3;
    logic [5:0] const3;

    logic       start4, valid4, ready4, done4, magic4;
    logic [4:0] data4;
    logic [6:0] const4;

    int errors = 0;
    int checks = 0;

    magic_square_seq #(.N(3), .W(4)) dut3 (
        .clock          (clock),
        .reset_L        (reset_L),
        .start          (start3),
        .cell_valid     (valid3),
        .cell_data      (data3),
        .cell_ready     (ready3),
        .done           (done3),
        .it_is_magic    (magic3),
        .magic_constant (const3)
    );

    magic_square_seq #(.N(4), .W(5)) dut4 (
        .clock          (clock),
        .reset_L        (reset_L),
        .start          (start4),
        .cell_valid     (valid4),
        .cell_data      (data4),
        .cell_ready     (ready4),
        .done           (done4),
        .it_is_magic    (magic4),
        .magic_constant (const4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every row, column and both diagonals must equal the row-0 sum.
    function automatic void model(input int n, input int g[$], output int magic, output int konst);
        int s;
        int d;
        int a;
        bit used [0:63];
        konst = 0;
        d = 0;
        a = 0;
        magic = 1;
        for (int c = 0; c < n; c++) konst += g[c];
        for (int r = 0; r < n; r++) begin
            s = 0;
            for (int c = 0; c < n; c++) s += g[r*n + c];
            if (s != konst) magic = 0;
        end
        for (int c = 0; c < n; c++) begin
            s = 0;
            for (int r = 0; r < n; r++) s += g[r*n + c];
            if (s != konst) magic = 0;
        end
        for (int i = 0; i < n; i++) begin
            d += g[i*n + i];
            a += g[i*n + (n - 1 - i)];
        end
        if (d != konst || a != konst) magic = 0;
`ifdef MAGIC_NORMAL_CHECK_EN
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        foreach (g[i]) begin
            if (g[i] < 1 || g[i] > n*n || used[g[i]]) magic = 0;
            else used[g[i]] = 1'b1;
        end
`else
        used[0] = 1'b0;
`endif
    endfunction

    // One of the 8 rotations/reflections of a 3x3 grid.
    function automatic void sym(input int src[$], input int t, output int dst[$]);
        dst = {};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int rr;
                int cc;
                int tmp;
                rr = r;
                cc = c;
                if ((t & 1) != 0) begin tmp = rr; rr = cc; cc = tmp; end
                if ((t & 2) != 0) rr = 2 - rr;
                if ((t & 4) != 0) cc = 2 - cc;
                dst.push_back(src[rr*3 + cc]);
            end
        end
    endfunction

    task automatic drive(input int sel, input logic s, input logic v, input int d);
        if (sel == 3) begin start3 = s; valid3 = v; data3 = 4'(d); end
        else          begin start4 = s; valid4 = v; data4 = 5'(d); end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 3) ? ready3 : ready4;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 3) ? done3 : done4;
    endfunction
    function automatic logic get_magic(input int sel);
        return (sel == 3) ? magic3 : magic4;
    endfunction
    function automatic logic [31:0] get_const(input int sel);
        return (sel == 3) ? 32'(const3) : 32'(const4);
    endfunction

    task automatic send_grid(input int sel, input int n, input int g[$], input int gap_max,
                             input bit glitch, input string tag);
        int exp_m;
        int exp_c;
        int t;
        int timeouts;
        model(n, g, exp_m, exp_c);
        timeouts = 0;
        @(negedge clock); drive(sel, 1'b1, 1'b0, 0);
        @(negedge clock); drive(sel, 1'b0, 1'b0, 0);
        check({tag, "_done_clr"}, 32'(get_done(sel)), 32'd0);
        for (int i = 0; i < n*n; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clock);
            drive(sel, glitch && (i == 4), 1'b1, g[i]);
            t = 0;
            while (!get_rdy(sel) && t < 50) begin @(negedge clock); t++; end
            if (t >= 50) timeouts++;
            @(negedge clock);
            drive(sel, 1'b0, 1'b0, 0);
        end
        check({tag, "_rdy_timeouts"}, 32'(timeouts), 32'd0);
        // Edge e below is the e-th edge after the one that took the last cell.
        for (int e = 1; e <= n + 2; e++) begin
            drive(sel, glitch && (e == 2), 1'b0, 0);
            @(negedge clock);
            if (e == 1)     check({tag, "_chk_rdy"}, 32'(get_rdy(sel)), 32'd0);
            if (e == n + 1) check({tag, "_done_early"}, 32'(get_done(sel)), 32'd0);
            if (e == n + 2) check({tag, "_done_lat"}, 32'(get_done(sel)), 32'd1);
        end
        drive(sel, 1'b0, 1'b0, 0);
        check({tag, "_magic"}, 32'(get_magic(sel)), 32'(exp_m));
        check({tag, "_const"}, get_const(sel), 32'(exp_c));
        repeat (2) @(negedge clock);
        check({tag, "_hold"}, 32'(get_done(sel)), 32'd1);
    endtask

    initial begin
        int lo_shu [$] = '{2, 7, 6, 9, 5, 1, 4, 3, 8};
        int g123   [$] = '{1, 2, 3, 2, 3, 1, 3, 1, 2};
        int all5   [$] = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
        int g816   [$] = '{8, 1, 6, 3, 5, 7, 4, 9, 2};
        int durer  [$] = '{16, 3, 2, 13, 5, 10, 11, 8, 9, 6, 7, 12, 4, 15, 14, 1};

        reset_L = 1'b0;
        drive(3, 1'b0, 1'b0, 0);
        drive(4, 1'b0, 1'b0, 0);
        #12;
        check("rst_done",  32'(done3),  32'd0);
        check("rst_magic", 32'(magic3), 32'd0);
        check("rst_const", 32'(const3), 32'd0);
        check("rst_rdy",   32'(ready3), 32'd0);
        check("rst_done4", 32'(done4),  32'd0);
        @(negedge clock);
        reset_L = 1'b1;

        send_grid(3, 3, lo_shu, 0, 1'b0, "loshu");
        send_grid(3, 3, g123,   0, 1'b0, "anti9");
        send_grid(3, 3, all5,   3, 1'b0, "all5");
        send_grid(4, 4, durer,  2, 1'b0, "durer");

        // Abort a grid after five cells with an asynchronous reset.
        @(negedge clock); drive(3, 1'b1, 1'b0, 0);
        @(negedge clock); drive(3, 1'b0, 1'b1, lo_shu[0]);
        for (int i = 1; i < 5; i++) begin
            @(negedge clock); drive(3, 1'b0, 1'b1, lo_shu[i]);
        end
        @(negedge clock); drive(3, 1'b0, 1'b0, 0);
        #2 reset_L = 1'b0;
        #1;
        check("arst_rdy",  32'(ready3), 32'd0);
        check("arst_done", 32'(done3),  32'd0);
        @(negedge clock);
        check("arst_rdy_next",   32'(ready3), 32'd0);
        check("arst_const_next", 32'(const3), 32'd0);
        reset_L = 1'b1;

        send_grid(3, 3, lo_shu, 0, 1'b0, "loshu_rst");
        send_grid(3, 3, lo_shu, 1, 1'b1, "glitch");
        send_grid(3, 3, g816,   0, 1'b0, "second");

        for (int it = 0; it < 8; it++) begin
            int g[$];
            int off;
            int idx;
            sym(lo_shu, $urandom_range(0, 7), g);
            off = $urandom_range(0, 6);
            foreach (g[i]) g[i] += off;
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 8);
                g[idx] = (g[idx] + 1) % 16;
            end
            send_grid(3, 3, g, $urandom_range(0, 3), 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
